// File: rtl/hazard_unit_param.sv
// Hazard unit for the 5-stage RV32 pipeline: load-use stall, operand forwarding,
// branch flush, data-memory wait freeze, and saturating stall/flush perf counters.
module hazard_unit_param #(
  parameter int REG_AW    = 5,
  parameter int MEM_LAT   = 1,
  parameter int WAIT_MODE = 0,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_regwrite,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic              ex_memread,
  input  logic              mem_memread,
  input  logic              mem_ready,
  input  logic              branch_taken,
  input  logic              cnt_clr,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              freeze,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int WMAX = (TIMEOUT > MEM_LAT) ? TIMEOUT : MEM_LAT;
  localparam int WCW  = $clog2(WMAX + 1);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             frz;
  logic             lu;

  // ex_regwrite is implied by ex_memread for a load, so only the load flag matters here
  logic unused_ex_regwrite;
  assign unused_ex_regwrite = ex_regwrite;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (mem_regwrite && (mem_rd != '0) && (mem_rd == id_rs1))
        fwd_a = 2'b10;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs1))
        fwd_a = 2'b01;
      if (mem_regwrite && (mem_rd != '0) && (mem_rd == id_rs2))
        fwd_b = 2'b10;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs2))
        fwd_b = 2'b01;
    end
  end

  always_comb begin
    lu = ex_memread && (ex_rd != '0) &&
         ((id_rs1_used && (ex_rd == id_rs1)) || (id_rs2_used && (ex_rd == id_rs2)));
  end

  // Wait FSM: fixed countdown or ready handshake, chosen at elaboration
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    frz           = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (WAIT_MODE == 0) begin
          if (mem_memread && (MEM_LAT > 1)) begin
            frz     = 1'b1;
            wcnt_d  = WCW'(MEM_LAT - 2);
            state_d = ST_WAIT;
          end
        end else begin
          if (mem_memread && !mem_ready) begin
            frz     = 1'b1;
            wcnt_d  = WCW'(1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (WAIT_MODE == 0) begin
          if (wcnt_q != '0) begin
            frz    = 1'b1;
            wcnt_d = wcnt_q - 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          if (mem_ready) begin
            state_d = ST_RUN;
          end else if (wcnt_q == WCW'(TIMEOUT)) begin
            mem_timeout_d = 1'b1;
            state_d       = ST_RUN;
          end else begin
            frz    = 1'b1;
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Priority: freeze over flush over load-use
  always_comb begin
    freeze      = !reset && frz;
    flush_if_id = !reset && branch_taken && !frz;
    flush_id_ex = flush_if_id;
    stall_if    = !reset && (frz || (lu && !branch_taken));
    stall_id    = stall_if;
    bubble_ex   = !reset && lu && !branch_taken && !frz;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (cnt_clr) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end else begin
      if (stall_if && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
      if (flush_if_id && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wcnt_q         <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_unit_param.sv
// Bench for hazard_unit_param: instance A (fixed MEM_LAT=3, CNT_W=4) and
// instance B (ready mode, TIMEOUT=8), checked through an expected-value queue.
module tb_hazard_unit_param;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] exrd, memrd, wbrd;
    logic       exrw, memrw, wbrw, exmr, mra, mrb, rdy, br, clr;
  } stim_t;

  typedef struct {
    stim_t       s;
    string       name;
    logic [10:0] ea, eb;
    bit          ca, cb;
  } row_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_rs1_used, id_rs2_used, ex_regwrite, mem_regwrite, wb_regwrite;
  logic ex_memread, mem_memread_a, mem_memread_b, mem_ready, branch_taken, cnt_clr;

  logic stall_if_a, stall_id_a, bubble_ex_a, freeze_a, flush_if_id_a, flush_id_ex_a, mem_timeout_a;
  logic [1:0] fwd_a_a, fwd_b_a;
  logic [3:0] stall_cycles_a, flush_count_a;
  logic stall_if_b, stall_id_b, bubble_ex_b, freeze_b, flush_if_id_b, flush_id_ex_b, mem_timeout_b;
  logic [1:0] fwd_a_b, fwd_b_b;
  logic [15:0] stall_cycles_b, flush_count_b;

  logic [10:0] oa, ob;
  int checks = 0;
  int failures = 0;
  stim_t cur;
  row_t rows[$];
  row_t exp_q[$];
  int cnt_q[$];

  always #5 clk = ~clk;

  hazard_unit_param #(.REG_AW(5), .MEM_LAT(3), .WAIT_MODE(0), .TIMEOUT(64), .CNT_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .ex_memread(ex_memread), .mem_memread(mem_memread_a), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .cnt_clr(cnt_clr),
    .stall_if(stall_if_a), .stall_id(stall_id_a), .bubble_ex(bubble_ex_a), .freeze(freeze_a),
    .flush_if_id(flush_if_id_a), .flush_id_ex(flush_id_ex_a), .fwd_a(fwd_a_a), .fwd_b(fwd_b_a),
    .mem_timeout(mem_timeout_a), .stall_cycles(stall_cycles_a), .flush_count(flush_count_a)
  );

  hazard_unit_param #(.REG_AW(5), .MEM_LAT(1), .WAIT_MODE(1), .TIMEOUT(8), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .ex_memread(ex_memread), .mem_memread(mem_memread_b), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .cnt_clr(cnt_clr),
    .stall_if(stall_if_b), .stall_id(stall_id_b), .bubble_ex(bubble_ex_b), .freeze(freeze_b),
    .flush_if_id(flush_if_id_b), .flush_id_ex(flush_id_ex_b), .fwd_a(fwd_a_b), .fwd_b(fwd_b_b),
    .mem_timeout(mem_timeout_b), .stall_cycles(stall_cycles_b), .flush_count(flush_count_b)
  );

  assign oa = {stall_if_a, stall_id_a, bubble_ex_a, freeze_a, flush_if_id_a, flush_id_ex_a,
               fwd_a_a, fwd_b_a, mem_timeout_a};
  assign ob = {stall_if_b, stall_id_b, bubble_ex_b, freeze_b, flush_if_id_b, flush_id_ex_b,
               fwd_a_b, fwd_b_b, mem_timeout_b};

  function automatic logic [10:0] mk(input logic st, input logic bub, input logic frz,
                                     input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                                     input logic to);
    return {st, st, bub, frz, fl, fl, fa, fb, to};
  endfunction

  task automatic apply(input stim_t s);
    reset = s.rst;           id_rs1 = s.rs1;          id_rs2 = s.rs2;
    id_rs1_used = s.u1;      id_rs2_used = s.u2;      ex_rd = s.exrd;
    mem_rd = s.memrd;        wb_rd = s.wbrd;          ex_regwrite = s.exrw;
    mem_regwrite = s.memrw;  wb_regwrite = s.wbrw;    ex_memread = s.exmr;
    mem_memread_a = s.mra;   mem_memread_b = s.mrb;   mem_ready = s.rdy;
    branch_taken = s.br;     cnt_clr = s.clr;
  endtask

  task automatic add(input string n, input logic [10:0] ea, input logic [10:0] eb,
                     input bit ca, input bit cb);
    row_t r;
    r.s = cur; r.name = n; r.ea = ea; r.eb = eb; r.ca = ca; r.cb = cb;
    rows.push_back(r);
  endtask

  task automatic set_lu();
    cur.exmr = 1'b1; cur.exrd = 5'd5; cur.rs1 = 5'd5; cur.u1 = 1'b1;
  endtask

  task automatic test_reset();
    row_t r, e;
    cur = '0; cur.rst = 1'b1; set_lu(); cur.br = 1'b1; cur.mra = 1'b1; cur.mrb = 1'b1;
    cur.memrd = 5'd3; cur.memrw = 1'b1; cur.rs2 = 5'd3;
    add("reset_outputs", '0, '0, 1'b1, 1'b1);
    while (rows.size() > 0) begin
      r = rows.pop_front(); apply(r.s); exp_q.push_back(r);
      @(negedge clk); e = exp_q.pop_front();
      if (e.ca) begin checks++; if (oa !== e.ea) begin failures++; $display("FAIL %s dut_a got=%b exp=%b", e.name, oa, e.ea); end end
      if (e.cb) begin checks++; if (ob !== e.eb) begin failures++; $display("FAIL %s dut_b got=%b exp=%b", e.name, ob, e.eb); end end
    end
    checks++;
    if (stall_cycles_a !== 4'd0 || flush_count_a !== 4'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles_a, flush_count_a);
    end
    @(posedge clk); #1;
    cur = '0; apply(cur);
  endtask

  task automatic test_forwarding();
    row_t r, e;
    cur = '0; cur.memrd = 5'd3; cur.memrw = 1'b1; cur.wbrd = 5'd3; cur.wbrw = 1'b1; cur.rs2 = 5'd3;
    add("fwd_b_exmem", mk(0,0,0,0,2'b00,2'b10,0), '0, 1'b1, 1'b0);
    cur.memrw = 1'b0;
    add("fwd_b_memwb", mk(0,0,0,0,2'b00,2'b01,0), '0, 1'b1, 1'b0);
    cur.memrw = 1'b1; cur.memrd = 5'd0; cur.wbrd = 5'd0; cur.rs2 = 5'd0;
    add("fwd_x0", mk(0,0,0,0,2'b00,2'b00,0), '0, 1'b1, 1'b0);
    cur = '0; cur.rs1 = 5'd7; cur.rs2 = 5'd7; cur.memrd = 5'd7; cur.memrw = 1'b1;
    cur.wbrd = 5'd7; cur.wbrw = 1'b1;
    add("fwd_both_exmem", mk(0,0,0,0,2'b10,2'b10,0), '0, 1'b1, 1'b0);
    cur = '0; cur.rs1 = 5'd9; cur.rs2 = 5'd4; cur.memrd = 5'd4; cur.memrw = 1'b1;
    cur.wbrd = 5'd9; cur.wbrw = 1'b1;
    add("fwd_split", mk(0,0,0,0,2'b01,2'b10,0), '0, 1'b1, 1'b0);
    cur.wbrw = 1'b0;
    add("fwd_wb_nowrite", mk(0,0,0,0,2'b00,2'b10,0), '0, 1'b1, 1'b0);
    while (rows.size() > 0) begin
      r = rows.pop_front(); apply(r.s); exp_q.push_back(r);
      @(negedge clk); e = exp_q.pop_front();
      if (e.ca) begin checks++; if (oa !== e.ea) begin failures++; $display("FAIL %s dut_a got=%b exp=%b", e.name, oa, e.ea); end end
      if (e.cb) begin checks++; if (ob !== e.eb) begin failures++; $display("FAIL %s dut_b got=%b exp=%b", e.name, ob, e.eb); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t r, e;
    cur = '0; set_lu(); cur.exrw = 1'b1;
    add("lu_rs1_stall", mk(1,1,0,0,2'b00,2'b00,0), '0, 1'b1, 1'b0);
    cur = '0;
    add("lu_bubble_next", '0, '0, 1'b1, 1'b0);
    cur = '0; cur.exmr = 1'b1; cur.exrd = 5'd0; cur.rs1 = 5'd0; cur.u1 = 1'b1;
    add("lu_x0_guard", '0, '0, 1'b1, 1'b0);
    cur = '0; cur.exmr = 1'b1; cur.exrd = 5'd6; cur.rs2 = 5'd6; cur.rs1 = 5'd1; cur.u1 = 1'b1;
    add("lu_rs2_unused", '0, '0, 1'b1, 1'b0);
    cur.u2 = 1'b1;
    add("lu_rs2_stall", mk(1,1,0,0,2'b00,2'b00,0), '0, 1'b1, 1'b0);
    cur.exmr = 1'b0;
    add("lu_not_load", '0, '0, 1'b1, 1'b0);
    cur = '0; set_lu(); cur.u1 = 1'b0;
    add("lu_rs1_unused", '0, '0, 1'b1, 1'b0);
    while (rows.size() > 0) begin
      r = rows.pop_front(); apply(r.s); exp_q.push_back(r);
      @(negedge clk); e = exp_q.pop_front();
      if (e.ca) begin checks++; if (oa !== e.ea) begin failures++; $display("FAIL %s dut_a got=%b exp=%b", e.name, oa, e.ea); end end
      if (e.cb) begin checks++; if (ob !== e.eb) begin failures++; $display("FAIL %s dut_b got=%b exp=%b", e.name, ob, e.eb); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_priority();
    row_t r, e;
    cur = '0; set_lu(); cur.br = 1'b1;
    add("br_with_lu", mk(0,0,0,1,2'b00,2'b00,0), '0, 1'b1, 1'b0);
    cur = '0; cur.br = 1'b1;
    add("br_alone", mk(0,0,0,1,2'b00,2'b00,0), '0, 1'b1, 1'b0);
    cur = '0;
    add("br_idle", '0, '0, 1'b1, 1'b0);
    cur.mra = 1'b1; cur.br = 1'b1;
    add("br_in_freeze", mk(1,0,1,0,2'b00,2'b00,0), '0, 1'b1, 1'b0);
    set_lu();
    add("br_lu_in_freeze", mk(1,0,1,0,2'b00,2'b00,0), '0, 1'b1, 1'b0);
    add("br_after_release", mk(0,0,0,1,2'b00,2'b00,0), '0, 1'b1, 1'b0);
    cur = '0;
    add("br_done", '0, '0, 1'b1, 1'b0);
    while (rows.size() > 0) begin
      r = rows.pop_front(); apply(r.s); exp_q.push_back(r);
      @(negedge clk); e = exp_q.pop_front();
      if (e.ca) begin checks++; if (oa !== e.ea) begin failures++; $display("FAIL %s dut_a got=%b exp=%b", e.name, oa, e.ea); end end
      if (e.cb) begin checks++; if (ob !== e.eb) begin failures++; $display("FAIL %s dut_b got=%b exp=%b", e.name, ob, e.eb); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fixed_freeze();
    row_t r, e;
    logic [10:0] fz;
    fz = mk(1,0,1,0,2'b00,2'b00,0);
    cur = '0; cur.mra = 1'b1;
    add("fix_f1", fz, '0, 1'b1, 1'b0);
    add("fix_f2", fz, '0, 1'b1, 1'b0);
    add("fix_release", '0, '0, 1'b1, 1'b0);
    cur = '0;
    add("fix_run", '0, '0, 1'b1, 1'b0);
    cur.mra = 1'b1;
    add("b2b_l1_f1", fz, '0, 1'b1, 1'b0);
    add("b2b_l1_f2", fz, '0, 1'b1, 1'b0);
    add("b2b_l1_release", '0, '0, 1'b1, 1'b0);
    add("b2b_l2_f1", fz, '0, 1'b1, 1'b0);
    add("b2b_l2_f2", fz, '0, 1'b1, 1'b0);
    add("b2b_l2_release", '0, '0, 1'b1, 1'b0);
    cur = '0;
    add("b2b_run", '0, '0, 1'b1, 1'b0);
    while (rows.size() > 0) begin
      r = rows.pop_front(); apply(r.s); exp_q.push_back(r);
      @(negedge clk); e = exp_q.pop_front();
      if (e.ca) begin checks++; if (oa !== e.ea) begin failures++; $display("FAIL %s dut_a got=%b exp=%b", e.name, oa, e.ea); end end
      if (e.cb) begin checks++; if (ob !== e.eb) begin failures++; $display("FAIL %s dut_b got=%b exp=%b", e.name, ob, e.eb); end end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ready_wait();
    row_t r, e;
    logic [10:0] fz, fzt;
    fz  = mk(1,0,1,0,2'b00,2'b00,0);
    fzt = mk(0,0,0,0,2'b00,2'b00,1);
    cur = '0; cur.mrb = 1'b1;
    for (int i = 0; i < 4; i++) add($sformatf("rdy_wait_%0d", i), '0, fz, 1'b0, 1'b1);
    cur.rdy = 1'b1;
    add("rdy_done", '0, '0, 1'b0, 1'b1);
    cur = '0;
    add("rdy_run", '0, '0, 1'b0, 1'b1);
    cur.mrb = 1'b1; cur.rdy = 1'b1;
    add("rdy_same_cycle", '0, '0, 1'b0, 1'b1);
    cur = '0;
    add("rdy_no_wait", '0, '0, 1'b0, 1'b1);
    cur.mrb = 1'b1;
    for (int i = 0; i < 8; i++) add($sformatf("to_wait_%0d", i), '0, fz, 1'b0, 1'b1);
    add("to_release", '0, '0, 1'b0, 1'b1);
    cur = '0;
    add("to_sticky_1", '0, fzt, 1'b0, 1'b1);
    add("to_sticky_2", '0, fzt, 1'b0, 1'b1);
    cur.mrb = 1'b1; cur.rdy = 1'b1;
    add("to_sticky_load", '0, fzt, 1'b0, 1'b1);
    while (rows.size() > 0) begin
      r = rows.pop_front(); apply(r.s); exp_q.push_back(r);
      @(negedge clk); e = exp_q.pop_front();
      if (e.ca) begin checks++; if (oa !== e.ea) begin failures++; $display("FAIL %s dut_a got=%b exp=%b", e.name, oa, e.ea); end end
      if (e.cb) begin checks++; if (ob !== e.eb) begin failures++; $display("FAIL %s dut_b got=%b exp=%b", e.name, ob, e.eb); end end
      @(posedge clk); #1;
    end
    cur = '0; apply(cur);
  endtask

  task automatic test_counters();
    int ex;
    cur = '0; set_lu(); cur.clr = 1'b1; apply(cur);
    @(posedge clk); #1;
    cur.clr = 1'b0;
    for (int i = 0; i < 21; i++) begin
      if (i == 20) cur = '0;
      apply(cur); cnt_q.push_back((i > 15) ? 15 : i);
      @(negedge clk); ex = cnt_q.pop_front(); checks++;
      if (stall_cycles_a !== 4'(ex)) begin
        failures++; $display("FAIL stall_cnt_%0d got=%0d exp=%0d", i, stall_cycles_a, ex);
      end
      @(posedge clk); #1;
    end
    cur = '0; cur.br = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) cur = '0;
      apply(cur); cnt_q.push_back(j);
      @(negedge clk); ex = cnt_q.pop_front(); checks++;
      if (flush_count_a !== 4'(ex)) begin
        failures++; $display("FAIL flush_cnt_%0d got=%0d exp=%0d", j, flush_count_a, ex);
      end
      checks++;
      if (stall_cycles_a !== 4'd15) begin
        failures++; $display("FAIL stall_hold_%0d got=%0d exp=15", j, stall_cycles_a);
      end
      @(posedge clk); #1;
    end
    cur = '0; cur.clr = 1'b1; cur.br = 1'b1; set_lu(); apply(cur);
    @(posedge clk); #1;
    cur = '0; apply(cur);
    @(negedge clk); checks++;
    if (stall_cycles_a !== 4'd0 || flush_count_a !== 4'd0) begin
      failures++; $display("FAIL cnt_clr got=%0d/%0d exp=0/0", stall_cycles_a, flush_count_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait();
    row_t r, e;
    cur = '0; cur.mra = 1'b1; cur.mrb = 1'b1;
    add("rw_enter", mk(1,0,1,0,2'b00,2'b00,0), mk(1,0,1,0,2'b00,2'b00,1), 1'b1, 1'b1);
    cur.rst = 1'b1;
    add("rw_reset_1", '0, '0, 1'b1, 1'b0);
    add("rw_reset_2", '0, '0, 1'b1, 1'b1);
    cur = '0;
    add("rw_after_reset", '0, '0, 1'b1, 1'b1);
    add("rw_after_reset_2", '0, '0, 1'b1, 1'b1);
    while (rows.size() > 0) begin
      r = rows.pop_front(); apply(r.s); exp_q.push_back(r);
      @(negedge clk); e = exp_q.pop_front();
      if (e.ca) begin checks++; if (oa !== e.ea) begin failures++; $display("FAIL %s dut_a got=%b exp=%b", e.name, oa, e.ea); end end
      if (e.cb) begin checks++; if (ob !== e.eb) begin failures++; $display("FAIL %s dut_b got=%b exp=%b", e.name, ob, e.eb); end end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    cur = '0; cur.rst = 1'b1; apply(cur);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_fixed_freeze();
    test_ready_wait();
    test_counters();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
